// File: rtl/adder_sched_pkg.sv
// Shared constants and helpers for the adder-tree scheduler.
// Pulled in by the FIFO and the top with import adder_sched_pkg::*.
package adder_sched_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ADD_LENGTH   = 16;
    localparam int DEF_SUM_LENGTH   = 32;
    localparam int DEF_NUM_ADDEND   = 45;
    localparam int DEF_TREE_LATENCY = 6;
    localparam int DEF_FIFO_DEPTH   = 8;

    localparam int MAX_REQ  = 32;
    localparam int MAX_IDXW = 5;

    typedef enum logic [1:0] {
        CR_HOLD = 2'b00,
        CR_DEC  = 2'b01,
        CR_INC  = 2'b10,
        CR_BOTH = 2'b11
    } credit_op_e;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot grant, searching upward from ptr+1 with wrap at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !found) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (valid[idx[MAX_IDXW-1:0]]) begin
                    g[idx[MAX_IDXW-1:0]] = 1'b1;
                    found                = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_sched_fifo.sv
// Synchronous first-word-fall-through FIFO for scheduler responses.
// Head data is forced to zero while empty so idle outputs read as zero.
module adder_sched_fifo
    import adder_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = push_ok ? nxt(wr_q) : wr_q;
        rd_d  = pop_ok ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    // Credit accounting upstream must make this unreachable.
    a_no_push_full: assert property (
        @(posedge clk) disable iff (rst) !(push_i && full_o)
    );

endmodule

// File: rtl/adder_tree_sched.sv
// Round-robin, credit-protected scheduler sharing one pipelined adder tree.
// Define ADDER_SCHED_STATS_EN to add grant_cnt / stall_cnt statistics.
module adder_tree_sched
    import adder_sched_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ADD_LENGTH   = DEF_ADD_LENGTH,
    parameter int SUM_LENGTH   = DEF_SUM_LENGTH,
    parameter int NUM_ADDEND   = DEF_NUM_ADDEND,
    parameter int TREE_LATENCY = DEF_TREE_LATENCY,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*ADD_LENGTH*NUM_ADDEND-1:0] req_addends,
    output logic [ADD_LENGTH*NUM_ADDEND-1:0]         tree_addends,
    input  logic [SUM_LENGTH-1:0]                    tree_sum,
    output logic                                     rsp_valid,
    input  logic                                     rsp_ready,
    output logic [idw(NUM_REQ)-1:0]                  rsp_id,
    output logic [SUM_LENGTH-1:0]                    rsp_sum,
    output logic                                     busy
`ifdef ADDER_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]                    grant_cnt,
    output logic [31:0]                              stall_cnt
`endif
);

    localparam int W   = ADD_LENGTH * NUM_ADDEND;
    localparam int IDW = idw(NUM_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FW  = IDW + SUM_LENGTH;
    localparam int TL  = TREE_LATENCY;

    logic [IDW-1:0]         ptr_q, ptr_d, gnt_idx;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           add_q, add_d;
    logic [TL:0]            tag_vld_q, tag_vld_d;
    logic [TL:0][IDW-1:0]   tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]     pick;
    logic                   can_issue, grant, pop;
    logic                   fifo_full, fifo_empty;
    logic [FW-1:0]          fifo_dout;
    credit_op_e             cr_op;

    assign can_issue = (cnt_q < CW'(FIFO_DEPTH));
    assign pick      = NUM_REQ'(rr_pick(MAX_REQ'(req_valid),
                                        int'(ptr_q), NUM_REQ));
    assign req_ready = (rst || !can_issue) ? '0 : pick;
    assign grant     = |req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign cr_op     = credit_op_e'({grant, pop});

    always_comb begin
        gnt_idx = '0;
        add_d   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx = IDW'(i);
                add_d   = req_addends[i*W +: W];
            end
        end
        ptr_d = grant ? gnt_idx : ptr_q;
    end

    // Tags travel alongside the tree so each sum knows its owner.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = grant;
        tag_id_d[0]  = gnt_idx;
        for (int k = 1; k <= TL; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (cr_op)
            CR_INC:  cnt_d = cnt_q + 1'b1;
            CR_DEC:  cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= IDW'(NUM_REQ - 1);
            cnt_q     <= '0;
            add_q     <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            add_q     <= add_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign tree_addends = add_q;
    assign busy         = (cnt_q != '0);

    adder_sched_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_vld_q[TL]),
        .din_i   ({tag_id_q[TL], tree_sum}),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rsp_valid         = ~fifo_empty;
    assign {rsp_id, rsp_sum} = fifo_dout;

`ifdef ADDER_SCHED_STATS_EN
    logic [NUM_REQ-1:0][31:0] gcnt_q;
    logic [31:0]              stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && gcnt_q[i] != '1)
                    gcnt_q[i] <= gcnt_q[i] + 32'd1;
            end
            if ((|req_valid) && !can_issue && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign grant_cnt = gcnt_q;
    assign stall_cnt = stall_q;
`endif

endmodule
